// File: rtl/gyropoint_gen.sv
// gyropoint_gen: gyroaveraging ring-point generator (N_GYRO points per particle, LANES per beat).
// Define GYROPOINT_CLAMP_EN for clamped (non-periodic) boundaries; the default build wraps modulo 2^PWIDTH.
module gyropoint_gen #(
  parameter int PWIDTH        = 16,
  parameter int RWIDTH        = 16,
  parameter int N_GYRO        = 4,
  parameter int LANES         = 4,
  parameter int NUM_PARTICLES = 16384,
  parameter int CNT_W         = $clog2(NUM_PARTICLES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PWIDTH-1:0]               in_y,
  input  logic [PWIDTH-1:0]               in_x,
  input  logic [RWIDTH-1:0]               in_radius,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*PWIDTH-1:0]         out_y,
  output logic [LANES*PWIDTH-1:0]         out_x,
  output logic [$clog2(N_GYRO/LANES):0]   out_beat,
  output logic                            out_last,
  output logic                            done
);

  localparam int NBEATS = N_GYRO / LANES;
  localparam int BW     = $clog2(NBEATS) + 1;
  localparam int EW     = PWIDTH + 1;
  localparam int MW     = RWIDTH + 17;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_PARTICLES - 1);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t            state, state_n;
  logic [PWIDTH-1:0] y_q, x_q;
  logic [RWIDTH-1:0] r_q, d_q, d_next;
  logic [MW-1:0]     d_prod;
  logic [BW-1:0]     beat_q;
  logic [CNT_W-1:0]  count;
  logic              done_q;
  logic              in_hs, last_hs, final_hs;

  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign out_beat  = beat_q;
  assign done      = done_q;
  assign last_hs   = out_valid && out_ready && out_last;
  assign final_hs  = last_hs && (count == LAST_CNT);

  // Diagonal offset r*cos(45deg), rounded; 46341/65536 ~= 1/sqrt(2).
  always_comb begin
    d_prod = MW'(in_radius) * MW'(46341) + MW'(32768);
    d_next = (N_GYRO == 8) ? RWIDTH'(d_prod >> 16) : '0;
  end

  function automatic logic [PWIDTH-1:0] step(input logic [PWIDTH-1:0] base,
                                             input logic [RWIDTH-1:0] off,
                                             input logic              sub);
    logic [EW-1:0] res;
    res = sub ? ({1'b0, base} - EW'(off)) : ({1'b0, base} + EW'(off));
`ifdef GYROPOINT_CLAMP_EN
    if (res[PWIDTH]) return sub ? '0 : '1;
`endif
    return PWIDTH'(res);
  endfunction

  // Octant index: a 4-point ring uses every second octant of the 8-point ring.
  always_comb begin
    int unsigned       k;
    int unsigned       oct;
    logic [PWIDTH-1:0] py, px;
    out_y = '0;
    out_x = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      k   = 32'(beat_q) * LANES + j;
      oct = (N_GYRO == 8) ? (k % 8) : ((2 * k) % 8);
      py  = y_q;
      px  = x_q;
      case (oct)
        0: px = step(x_q, r_q, 1'b0);
        1: begin py = step(y_q, d_q, 1'b0); px = step(x_q, d_q, 1'b0); end
        2: py = step(y_q, r_q, 1'b0);
        3: begin py = step(y_q, d_q, 1'b0); px = step(x_q, d_q, 1'b1); end
        4: px = step(x_q, r_q, 1'b1);
        5: begin py = step(y_q, d_q, 1'b1); px = step(x_q, d_q, 1'b1); end
        6: py = step(y_q, r_q, 1'b1);
        default: begin py = step(y_q, d_q, 1'b1); px = step(x_q, d_q, 1'b0); end
      endcase
      if (state == EMIT) begin
        out_y[j*PWIDTH +: PWIDTH] = py;
        out_x[j*PWIDTH +: PWIDTH] = px;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // in_ready in EMIT is combinational from out_ready so back-to-back particles have no bubble.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    in_hs    = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      EMIT:    in_ready = last_hs && (count != LAST_CNT);
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready && !rst;
    in_hs    = in_valid && in_ready;
    case (state)
      IDLE: if (in_hs) state_n = EMIT;
      EMIT: begin
        if (last_hs) begin
          if (final_hs && !clear) state_n = DONE;
          else if (in_hs)         state_n = EMIT;
          else                    state_n = IDLE;
        end
      end
      DONE:    if (clear) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      x_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      beat_q <= '0;
    end else begin
      if (in_hs) begin
        y_q <= in_y;
        x_q <= in_x;
        r_q <= in_radius;
        d_q <= d_next;
      end
      if (out_valid && out_ready)
        beat_q <= out_last ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      done_q <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      if (last_hs)  count  <= count + CNT_W'(1);
      if (final_hs) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gyropoint_gen.sv
// Bench for gyropoint_gen: an 8-point/2-lane instance (3 particles per pass) and a 4-point/4-lane instance,
// checked against a geometric ring model (octant sin/cos signs, r or r/sqrt2 offsets).
module tb_gyropoint_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clear = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, done;
  logic [15:0] in_y = '0, in_x = '0, in_radius = '0;
  logic [31:0] out_y, out_x;
  logic [2:0]  out_beat;

  logic        clear4 = 1'b0, in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_last4, done4;
  logic [15:0] in_y4 = '0, in_x4 = '0, in_radius4 = '0;
  logic [63:0] out_y4, out_x4;
  logic [0:0]  out_beat4;

  int pass_cnt = 0;
  int total    = 0;

  int cos_s [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int sin_s [8] = '{0, 1, 1, 1, 0, -1, -1, -1};

`ifdef GYROPOINT_CLAMP_EN
  localparam logic [15:0] WRAP_X0 = 16'hFFFF;
`else
  localparam logic [15:0] WRAP_X0 = 16'h0080;
`endif

  gyropoint_gen #(.PWIDTH(16), .RWIDTH(16), .N_GYRO(8), .LANES(2), .NUM_PARTICLES(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_x(in_x), .in_radius(in_radius), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_x(out_x), .out_beat(out_beat), .out_last(out_last), .done(done));

  gyropoint_gen #(.PWIDTH(16), .RWIDTH(16), .N_GYRO(4), .LANES(4), .NUM_PARTICLES(64)) dut4 (
    .clk(clk), .rst(rst), .clear(clear4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_y(in_y4), .in_x(in_x4), .in_radius(in_radius4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_y(out_y4), .out_x(out_x4), .out_beat(out_beat4), .out_last(out_last4), .done(done4));

  // Point k of an n-point ring sits at angle k*360/n; axis-aligned points use r, diagonals use round(r/sqrt2).
  function automatic logic [15:0] ref_coord(input bit is_y, input logic [15:0] y, x, r,
                                            input int n, input int k);
    longint base, mag, v;
    int     oct;
    oct  = (n == 8) ? k : 2 * k;
    mag  = (oct % 2 == 1) ? (longint'(r) * 46341 + 32768) / 65536 : longint'(r);
    base = is_y ? longint'(y) : longint'(x);
    v    = base + (is_y ? sin_s[oct] : cos_s[oct]) * mag;
`ifdef GYROPOINT_CLAMP_EN
    if (v > 65535) v = 65535;
    else if (v < 0) v = 0;
`else
    v = (v + 65536) % 65536;
`endif
    return 16'(v);
  endfunction

  function automatic logic [63:0] exp_lanes(input bit is_y, input logic [15:0] y, x, r,
                                            input int n, input int lanes, input int beat);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < lanes; j++) v[j*16 +: 16] = ref_coord(is_y, y, x, r, n, beat * lanes + j);
    return v;
  endfunction

  task automatic offer_a(input logic [15:0] y, x, r, output bit ok);
    ok = 1'b0;
    in_y = y; in_x = x; in_radius = r; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = (in_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_a(output bit ok);
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = (out_valid === 1'b1) && (out_last === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total++; if ({out_y, out_x} !== 64'h0) $display("FAIL reset_xy: got %h want 0", {out_y, out_x}); else pass_cnt++;
    total++; if ({out_beat, out_last, done} !== 5'b0) $display("FAIL reset_beat_last_done: got %b want 0", {out_beat, out_last, done}); else pass_cnt++;
    total++; if ({in_ready, in_ready4} !== 2'b00) $display("FAIL reset_in_ready: got %b want 00", {in_ready, in_ready4}); else pass_cnt++;
    total++; if ({out_valid4, done4} !== 2'b00) $display("FAIL reset_b: got %b want 00", {out_valid4, done4}); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++; if ({in_ready, in_ready4} !== 2'b11) $display("FAIL idle_in_ready: got %b want 11", {in_ready, in_ready4}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ring4();
    logic [63:0] ey, ex;
    ey = {16'h0F00, 16'h1000, 16'h1100, 16'h1000};
    ex = {16'h2000, 16'h1F00, 16'h2000, 16'h2100};
    in_y4 = 16'h1000; in_x4 = 16'h2000; in_radius4 = 16'h0100;
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0;
    total++; if ({out_valid4, out_last4, out_beat4} !== 3'b110) $display("FAIL ring4_ctrl: got %b want 110", {out_valid4, out_last4, out_beat4}); else pass_cnt++;
    total++; if (out_y4 !== ey) $display("FAIL ring4_y: got %h want %h", out_y4, ey); else pass_cnt++;
    total++; if (out_x4 !== ex) $display("FAIL ring4_x: got %h want %h", out_x4, ex); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total++; if (out_valid4 !== 1'b0) $display("FAIL ring4_idle: got %b want 0", out_valid4); else pass_cnt++;
  endtask

  task automatic test_back_to_back4();
    logic [15:0] ry [6], rx [6], rr [6];
    logic [63:0] ey, ex;
    for (int i = 0; i < 6; i++) begin
      ry[i] = 16'($urandom); rx[i] = 16'($urandom); rr[i] = 16'($urandom_range(0, 16'hFFFF));
    end
    out_ready4 = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c < 6) begin
        in_valid4 = 1'b1; in_y4 = ry[c]; in_x4 = rx[c]; in_radius4 = rr[c];
      end else begin
        in_valid4 = 1'b0;
      end
      #1;
      total++; if (in_ready4 !== 1'b1) $display("FAIL b2b4_in_ready c=%0d: got %b want 1", c, in_ready4); else pass_cnt++;
      if (c > 0) begin
        ey = exp_lanes(1'b1, ry[c-1], rx[c-1], rr[c-1], 4, 4, 0);
        ex = exp_lanes(1'b0, ry[c-1], rx[c-1], rr[c-1], 4, 4, 0);
        total++; if ({out_valid4, out_last4} !== 2'b11) $display("FAIL b2b4_valid c=%0d: got %b want 11", c, {out_valid4, out_last4}); else pass_cnt++;
        total++; if ({out_y4, out_x4} !== {ey, ex}) $display("FAIL b2b4_points c=%0d: got %h want %h", c, {out_y4, out_x4}, {ey, ex}); else pass_cnt++;
      end
      @(posedge clk); @(negedge clk);
    end
    total++; if (out_valid4 !== 1'b0) $display("FAIL b2b4_end: got %b want 0", out_valid4); else pass_cnt++;
  endtask

  task automatic test_ring8();
    logic [63:0] ey, ex;
    bit ok;
    out_ready = 1'b1;
    offer_a(16'h4000, 16'h8000, 16'h1000, ok);
    total++; if (!ok) $display("FAIL ring8_accept: got timeout want accept"); else pass_cnt++;
    total++; if ({out_y[31:16], out_x[31:16]} !== {16'h4B50, 16'h8B50}) $display("FAIL ring8_point1: got %h want 4b508b50", {out_y[31:16], out_x[31:16]}); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      ey = exp_lanes(1'b1, 16'h4000, 16'h8000, 16'h1000, 8, 2, b);
      ex = exp_lanes(1'b0, 16'h4000, 16'h8000, 16'h1000, 8, 2, b);
      total++; if ({out_valid, out_beat, out_last} !== {1'b1, 3'(b), (b == 3)}) $display("FAIL ring8_ctrl b=%0d: got %b want %b", b, {out_valid, out_beat, out_last}, {1'b1, 3'(b), (b == 3)}); else pass_cnt++;
      total++; if ({out_y, out_x} !== {ey[31:0], ex[31:0]}) $display("FAIL ring8_points b=%0d: got %h want %h", b, {out_y, out_x}, {ey[31:0], ex[31:0]}); else pass_cnt++;
      @(posedge clk); @(negedge clk);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL ring8_end: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [63:0] ey;
    bit ok;
    offer_a(16'h8000, 16'hFF80, 16'h0100, ok);
    total++; if (!ok) $display("FAIL wrap_accept: got timeout want accept"); else pass_cnt++;
    total++; if (out_x[15:0] !== WRAP_X0) $display("FAIL wrap_x0: got %h want %h", out_x[15:0], WRAP_X0); else pass_cnt++;
    ey = exp_lanes(1'b1, 16'h8000, 16'hFF80, 16'h0100, 8, 2, 0);
    total++; if (out_y !== ey[31:0]) $display("FAIL wrap_y: got %h want %h", out_y, ey[31:0]); else pass_cnt++;
    drain_a(ok);
    total++; if (!ok) $display("FAIL wrap_drain: got timeout want last beat"); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [15:0] y, x, r;
    logic [63:0] ey, ex;
    bit ok;
    y = 16'($urandom); x = 16'($urandom); r = 16'($urandom);
    out_ready = 1'b1;
    offer_a(y, x, r, ok);
    total++; if (!ok) $display("FAIL bp_accept: got timeout want accept"); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    ey = exp_lanes(1'b1, y, x, r, 8, 2, 1);
    ex = exp_lanes(1'b0, y, x, r, 8, 2, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if ({out_valid, out_beat, in_ready, out_y, out_x} !== {1'b1, 3'd1, 1'b0, ey[31:0], ex[31:0]})
        $display("FAIL bp_hold c=%0d: got %h want %h", c, {out_valid, out_beat, in_ready, out_y, out_x}, {1'b1, 3'd1, 1'b0, ey[31:0], ex[31:0]}); else pass_cnt++;
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      ey = exp_lanes(1'b1, y, x, r, 8, 2, b);
      ex = exp_lanes(1'b0, y, x, r, 8, 2, b);
      #1;
      total++; if ({out_valid, out_beat, out_y, out_x} !== {1'b1, 3'(b), ey[31:0], ex[31:0]}) $display("FAIL bp_beat b=%0d: got %h want %h", b, {out_valid, out_beat, out_y, out_x}, {1'b1, 3'(b), ey[31:0], ex[31:0]}); else pass_cnt++;
      if (b == 3) begin
        total++; if (in_ready !== 1'b0) $display("FAIL bp_final_in_ready: got %b want 0", in_ready); else pass_cnt++;
      end
      @(posedge clk); @(negedge clk);
    end
    total++; if ({done, out_valid, in_ready} !== 3'b100) $display("FAIL bp_done: got %b want 100", {done, out_valid, in_ready}); else pass_cnt++;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({in_ready, out_valid, done} !== 3'b001) $display("FAIL done_hold c=%0d: got %b want 001", c, {in_ready, out_valid, done}); else pass_cnt++;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clear_done();
    logic [15:0] ry [3], rx [3], rr [3];
    logic [63:0] ey, ex;
    int p, b;
    for (int i = 0; i < 3; i++) begin
      ry[i] = 16'($urandom); rx[i] = 16'($urandom); rr[i] = 16'($urandom);
    end
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    #1;
    total++; if ({done, in_ready} !== 2'b01) $display("FAIL clear: got %b want 01", {done, in_ready}); else pass_cnt++;
    out_ready = 1'b1;
    in_valid = 1'b1; in_y = ry[0]; in_x = rx[0]; in_radius = rr[0];
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      p = c / 4; b = c % 4;
      ey = exp_lanes(1'b1, ry[p], rx[p], rr[p], 8, 2, b);
      ex = exp_lanes(1'b0, ry[p], rx[p], rr[p], 8, 2, b);
      total++; if ({out_valid, out_beat, out_last, done, out_y, out_x} !== {1'b1, 3'(b), (b == 3), 1'b0, ey[31:0], ex[31:0]})
        $display("FAIL b2b8 c=%0d: got %h want %h", c, {out_valid, out_beat, out_last, done, out_y, out_x}, {1'b1, 3'(b), (b == 3), 1'b0, ey[31:0], ex[31:0]}); else pass_cnt++;
      if (b == 3 && p < 2) begin
        in_valid = 1'b1; in_y = ry[p+1]; in_x = rx[p+1]; in_radius = rr[p+1];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      total++; if (in_ready !== (b == 3 && p < 2)) $display("FAIL b2b8_in_ready c=%0d: got %b want %b", c, in_ready, (b == 3 && p < 2)); else pass_cnt++;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    total++; if ({done, in_ready, out_valid} !== 3'b100) $display("FAIL b2b8_done: got %b want 100", {done, in_ready, out_valid}); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [63:0] ey, ex;
    bit ok;
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer_a(16'($urandom), 16'($urandom), 16'($urandom), ok);
      drain_a(ok);
    end
    offer_a(16'h1234, 16'h5678, 16'h0200, ok);
    @(posedge clk); @(negedge clk);
    total++; if (out_beat !== 3'd1) $display("FAIL ares_pre_beat: got %0d want 1", out_beat); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if ({out_valid, out_beat, out_last, in_ready, done} !== 7'b0) $display("FAIL ares_ctrl: got %b want 0", {out_valid, out_beat, out_last, in_ready, done}); else pass_cnt++;
    total++; if ({out_y, out_x} !== 64'h0) $display("FAIL ares_xy: got %h want 0", {out_y, out_x}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    offer_a(16'h0100, 16'h0200, 16'h0300, ok);
    total++; if (!ok) $display("FAIL ares_accept: got timeout want accept"); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      ey = exp_lanes(1'b1, 16'h0100, 16'h0200, 16'h0300, 8, 2, b);
      ex = exp_lanes(1'b0, 16'h0100, 16'h0200, 16'h0300, 8, 2, b);
      #1;
      total++; if ({out_valid, out_beat, out_y, out_x} !== {1'b1, 3'(b), ey[31:0], ex[31:0]}) $display("FAIL ares_beat b=%0d: got %h want %h", b, {out_valid, out_beat, out_y, out_x}, {1'b1, 3'(b), ey[31:0], ex[31:0]}); else pass_cnt++;
      if (b == 3) begin
        total++; if (in_ready !== 1'b1) $display("FAIL ares_count_cleared: got in_ready %b want 1", in_ready); else pass_cnt++;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ring4();
    test_back_to_back4();
    test_ring8();
    test_wrap();
    test_backpressure();
    test_clear_done();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gyropoint_gen.md
# gyropoint_gen

Parametrised gyroaveraging point generator for the scatter path. It sits between the gyroradius divider and the charge accumulators. For each particle it accepts the gyrocenter and gyroradius, then emits N_GYRO ring points in LANES-wide beats with a valid/ready handshake. It also counts completed particles and raises a sticky `done`. Compared with the fixed 4-point, always-valid scatter stage, it adds 8-point rings, lane-width selection, backpressure and a clearable particle counter.

## Interface
- `PWIDTH`, 16: position width per axis; unsigned fixed point, full range = one grid period.
- `RWIDTH`, 16: gyroradius width; unsigned, same LSB weight as position.
- `N_GYRO`, 4: points per ring; legal values are 4 and 8.
- `LANES`, 4: points per output beat; legal values are 1, 2, 4, 8; must divide N_GYRO.
- `NUM_PARTICLES`, 16384: particles per pass.
- `CNT_W`, $clog2(NUM_PARTICLES+1): counter width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `clear` in 1: synchronous; zeroes the counter and `done`.
- `in_valid` in 1: particle offered.
- `in_ready` out 1: particle accepted when `in_valid && in_ready`.
- `in_y`, `in_x` in PWIDTH each: gyrocenter.
- `in_radius` in RWIDTH: gyroradius.
- `out_valid` out 1: beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_y`, `out_x` out LANES×PWIDTH each: gyropoints; lane j carries point `beat*LANES+j`.
- `out_beat` out $clog2(N_GYRO/LANES)+1: beat index within the particle.
- `out_last` out 1: final beat of the particle.
- `done` out 1: sticky; all NUM_PARTICLES emitted.

## Operation
- FSM states:
  - IDLE: `in_ready=1`.
  - EMIT: holding a particle.
  - DONE: `in_ready=0` and no outputs.
- Transitions:
  - IDLE→EMIT on input handshake.
  - EMIT→EMIT on a last-beat handshake with a new input handshake in the same cycle.
  - EMIT→IDLE on a last-beat handshake with no new input.
  - EMIT→DONE when the last-beat handshake brings the count to NUM_PARTICLES.
  - DONE→IDLE on `clear`.
- In EMIT, `in_ready = out_valid && out_ready && out_last && !(count == NUM_PARTICLES-1)`. This is a combinational path from `out_ready`.
- On accept, register y, x, r and d. d is the diagonal offset, `(r*46341 + 32768) >> 16`, width RWIDTH; it is computed only when N_GYRO=8.
- Point order, k = 0..N_GYRO-1:
  - N_GYRO=4: (y, x+r), (y+r, x), (y, x−r), (y−r, x).
  - N_GYRO=8: (y, x+r), (y+d, x+d), (y+r, x), (y+d, x−d), (y, x−r), (y−d, x−d), (y−r, x), (y−d, x+d).
- Arithmetic: zero-extend the offset to PWIDTH+1, add or subtract modulo 2^PWIDTH. Wrap-around is the periodic boundary; there is no saturation unless the macro below is defined.
- `out_beat` increments on each output handshake and resets to 0 after `out_last`.
- Outputs hold stable while `out_valid && !out_ready`.
- Counter increments on each last-beat handshake.
- `done` rises in the cycle after the count reaches NUM_PARTICLES and stays high until `clear` or `rst`.
- `clear` has priority over a simultaneous increment. A `clear` in EMIT zeroes the count but does not abort the particle in flight.
- Reset mid-particle drops the particle. No partial beats are emitted after reset.

## Timing
- Reset values: `out_valid=0`, `out_y=out_x=0`, `out_beat=0`, `out_last=0`, `done=0`, count=0, state IDLE. `in_ready=0` while `rst` is high.
- Latency: input handshake at edge t gives `out_valid=1` with beat 0 after edge t+1.
- Throughput: N_GYRO/LANES cycles per particle with `out_ready` held high. There are no bubbles between back-to-back particles.
- When LANES == N_GYRO, every beat is last (`out_last=1`) and the block sustains one particle per cycle.

## Configuration
- `GYROPOINT_CLAMP_EN`:
  - Defined: non-periodic boundary. A sum that overflows clamps to 2^PWIDTH−1; a difference that underflows clamps to 0. Logic is added to the add/sub path only.
  - Undefined: modular wrap as described above.

## Test plan
- N_GYRO=4, LANES=4: y=0x1000, x=0x2000, r=0x0100 → one beat: (0x1000,0x2100), (0x1100,0x2000), (0x1000,0x1F00), (0x0F00,0x2000); `out_last=1` at t+1.
- N_GYRO=8, LANES=2: r=0x1000 gives d=0x0B50 → four beats, beats 0..3, `out_last` on beat 3. Point 1 = (y+0x0B50, x+0x0B50).
- Wrap: x=0xFF80, r=0x0100 → point 0 x=0x0080. With `GYROPOINT_CLAMP_EN` defined, point 0 x=0xFFFF.
- Backpressure: hold `out_ready=0` for 5 cycles mid-particle → outputs stable, `in_ready=0`, no beat lost or duplicated.
- NUM_PARTICLES=3, 3 back-to-back particles → `done` rises one cycle after the 3rd `out_last` handshake and `in_ready=0` afterwards; `clear` → `done=0`, next particle accepted.
- Assert `rst` asynchronously during beat 1 of an 8-point ring → `out_valid=0` immediately, count=0, and the next particle starts at beat 0.
